// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the down-counting timer.
//   ST_IDLE / ST_RUN / ST_DONE : 2-bit state encodings of the timer FSM.
//   The remaining encoding (2'b11) is never entered and recovers to IDLE.
// -----------------------------------------------------------------------------
package timer_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage : timer_pkg

// File: rtl/down_counter_timer.sv
// -----------------------------------------------------------------------------
// down_counter_timer
// Programmable down-counting timer with one-shot and periodic (auto-reload)
// modes. A loaded value counts down to zero; tc pulses for one cycle when the
// count reaches zero by decrement.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   load        in   capture load_val into count and reload register, go IDLE
//   load_val    in   [WIDTH-1:0] value captured on load
//   start       in   begin / resume counting
//   stop        in   pause counting (count holds)
//   auto_reload in   1 = periodic, 0 = one-shot
//   count       out  [WIDTH-1:0] current counter value
//   busy        out  high while counting (RUN)
//   tc          out  one-cycle pulse when count reaches 0 by decrement
//   done        out  high while in DONE
// -----------------------------------------------------------------------------
module down_counter_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;

  // State, count, reload register and tc pulse; priority rst > load > stop > start > count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_count  <= CNT_ZERO;
      r_reload <= CNT_ZERO;
      r_tc     <= 1'b0;
    end else if (load) begin
      r_count  <= load_val;
      r_reload <= load_val;
      r_state  <= ST_IDLE;
      r_tc     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tc <= 1'b0;
          // Nothing to count from zero, so start is ignored there.
          if (start && (r_count != CNT_ZERO)) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_tc    <= 1'b0;
          end else if (r_count > CNT_ONE) begin
            r_count <= r_count - CNT_ONE;
            r_tc    <= 1'b0;
          end else if (r_count == CNT_ONE) begin
            // tc lands in the same cycle count shows zero.
            r_count <= CNT_ZERO;
            r_tc    <= 1'b1;
          end else if (auto_reload) begin
            // Zero is held for one cycle before reloading: period is N+1.
            r_count <= r_reload;
            r_tc    <= 1'b0;
          end else begin
            r_state <= ST_DONE;
            r_tc    <= 1'b0;
          end
        end
        ST_DONE: begin
          r_tc <= 1'b0;
          if (start && (r_reload != CNT_ZERO)) begin
            r_count <= r_reload;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tc    <= 1'b0;
        end
      endcase
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// -----------------------------------------------------------------------------
// tb_down_counter_timer
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model of the timer kept in this bench.
// -----------------------------------------------------------------------------
module tb_down_counter_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       auto_reload = 1'b0;
  logic [3:0] count;
  logic       busy;
  logic       tc;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  // Model: current value, value to reload, and whether counting / finished.
  int m_val    = 0;
  int m_reload = 0;
  bit m_run    = 1'b0;
  bit m_fin    = 1'b0;
  bit m_tc     = 1'b0;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .count(count), .busy(busy), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, {28'd0, count}, m_val);
    check({tag, ".busy"},  {31'd0, busy},  {31'd0, m_run});
    check({tag, ".done"},  {31'd0, done},  {31'd0, m_fin});
    check({tag, ".tc"},    {31'd0, tc},    {31'd0, m_tc});
  endtask

  // One clock edge of the timer's rules, applied to the model.
  task automatic model_edge(input bit ld, input int lv, input bit st, input bit sp, input bit ar);
    if (ld) begin
      m_val = lv; m_reload = lv; m_run = 0; m_fin = 0; m_tc = 0;
    end else if (m_run) begin
      m_tc = 0;
      if (sp) m_run = 0;
      else if (m_val >= 1) begin
        m_val = m_val - 1;
        m_tc  = (m_val == 0);
      end else if (ar) m_val = m_reload;
      else begin
        m_run = 0; m_fin = 1;
      end
    end else if (m_fin) begin
      m_tc = 0;
      if (st && m_reload != 0) begin
        m_val = m_reload; m_run = 1; m_fin = 0;
      end
    end else begin
      m_tc = 0;
      if (st && m_val != 0) m_run = 1;
    end
  endtask

  task automatic drive(input string tag, input bit ld, input int lv, input bit st, input bit sp, input bit ar);
    load = ld; load_val = lv[3:0]; start = st; stop = sp; auto_reload = ar;
    @(posedge clk);
    model_edge(ld, lv, st, sp, ar);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset asserted away from the clock edge.
  task automatic do_reset(input string tag);
    load = 0; start = 0; stop = 0;
    rst = 1'b1;
    #2;
    m_val = 0; m_reload = 0; m_run = 0; m_fin = 0; m_tc = 0;
    check({tag, ".count"}, {28'd0, count}, 32'd0);
    check({tag, ".busy"},  {31'd0, busy},  32'd0);
    check({tag, ".done"},  {31'd0, done},  32'd0);
    check({tag, ".tc"},    {31'd0, tc},    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset("por");

    // Reset mid-count at count 6.
    drive("mid_ld", 1, 9, 0, 0, 0);
    drive("mid_st", 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive("mid_run", 0, 0, 0, 0, 0);
    check("mid_at6", {28'd0, count}, 32'd6);
    do_reset("mid_rst");

    // One-shot from 5.
    drive("os_ld", 1, 5, 0, 0, 0);
    drive("os_st", 0, 0, 1, 0, 0);
    check("os_first", {28'd0, count}, 32'd5);
    for (int i = 0; i < 5; i++) drive("os_run", 0, 0, 0, 0, 0);
    check("os_zero_tc", {31'd0, tc}, 32'd1);
    drive("os_done", 0, 0, 0, 0, 0);
    check("os_done_lvl", {31'd0, done}, 32'd1);
    drive("os_hold", 0, 0, 0, 1, 0);

    // Periodic from 3: tc every 4 cycles.
    drive("per_ld", 1, 3, 0, 0, 1);
    drive("per_st", 0, 0, 1, 0, 1);
    for (int i = 0; i < 12; i++) drive("per_run", 0, 0, 0, 0, 1);

    // Pause at 4 and resume.
    drive("pr_ld", 1, 9, 0, 0, 0);
    drive("pr_st", 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive("pr_run", 0, 0, 0, 0, 0);
    drive("pr_stop", 0, 0, 0, 1, 0);
    check("pr_held", {28'd0, count}, 32'd4);
    drive("pr_idle", 0, 0, 0, 0, 0);
    drive("pr_resume", 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive("pr_run2", 0, 0, 0, 0, 0);

    // Collisions.
    drive("co_ldst", 1, 7, 1, 0, 0);
    check("co_ldst_busy", {31'd0, busy}, 32'd0);
    drive("co_st", 0, 0, 1, 0, 0);
    drive("co_both", 0, 0, 1, 1, 0);
    check("co_both_busy", {31'd0, busy}, 32'd0);
    drive("co_ld0", 1, 0, 0, 0, 0);
    drive("co_st0", 0, 0, 1, 1, 0);

    // Full range from 15, then restart from DONE.
    drive("fr_ld", 1, 15, 0, 0, 0);
    drive("fr_st", 0, 0, 1, 0, 0);
    for (int i = 0; i < 17; i++) drive("fr_run", 0, 0, 0, 0, 0);
    drive("fr_restart", 0, 0, 1, 0, 0);
    check("fr_restart_val", {28'd0, count}, 32'd15);
    for (int i = 0; i < 3; i++) drive("fr_run2", 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
      else drive("rnd", ($urandom_range(0, 19) == 0), $urandom_range(0, 15),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 14) == 0),
                 ($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_down_counter_timer

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Programmable down-counting timer, the decrementing counterpart of the team's free-running up counter. Counts a loaded value down to zero and flags terminal count. Optionally auto-reloads for periodic ticks. Used for timeouts, delays and periodic enables elsewhere in the design.

Parameters:
WIDTH, 4, bit width of count, load_val and the internal reload register.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
load  input  1  writes load_val into count and the reload register, then forces IDLE.
load_val  input  WIDTH  value captured on load.
start  input  1  begins or resumes counting.
stop  input  1  pauses counting; count holds its value.
auto_reload  input  1  1 = periodic mode, 0 = one-shot mode.
count  output  WIDTH  current counter value (registered).
busy  output  1  high while the state is RUN.
tc  output  1  one-cycle registered pulse when count reaches 0 by decrement.
done  output  1  level; high while the state is DONE.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. All outputs are registered.
- Reset (any time, including mid-count):
  - count=0, reload register=0, state=IDLE.
  - busy=0, tc=0, done=0.
- States: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
- Priority per edge, highest first: rst > load > stop > start > counting.
- load (any state):
  - count<=load_val; reload register<=load_val.
  - state<=IDLE; tc<=0.
  - A start or stop in the same cycle is ignored.
- IDLE:
  - start with count!=0 -> RUN. count is not decremented on that edge.
  - start with count==0 is ignored; state stays IDLE.
- RUN, on each edge:
  - stop asserted -> IDLE; count holds. A later start resumes from the held value.
  - count>1 -> count-1; tc<=0.
  - count==1 -> count<=0; tc<=1 (tc is visible in the same cycle count shows 0).
  - count==0 and auto_reload=1 -> count<=reload register; stay RUN; tc<=0.
  - count==0 and auto_reload=0 -> DONE; count stays 0; tc<=0.
  - auto_reload is sampled only on the edge where count==0.
- DONE:
  - start -> count<=reload register, state RUN.
  - If the reload register==0, start is ignored and the state stays DONE.
  - stop in DONE has no effect.
- Latency: after start with value N, count reaches 0 (and tc pulses) N edges later. done rises 1 edge after that.
- Period in auto_reload mode: N+1 cycles between tc pulses.
- No underflow: count never decrements below 0 and never wraps to all-ones.
- stop and start together: stop wins in RUN; in IDLE, start wins because stop is a no-op there.
- Arithmetic is unsigned WIDTH-bit; the decrement is only applied when count>=1.

Decomposition:
- Shared package timer_pkg holds the state encodings as localparams: ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10.
- Unused encoding 2'b11 recovers to IDLE.
- No sub-module. One sequential process for state, count, reload register and tc. busy and done are decoded from the registered state.

Test Plan:
1. Reset mid-count: rst pulsed asynchronously while count=6 in RUN -> immediately count=0, busy=0, done=0, tc=0; state IDLE.
2. One-shot: load 5, then start, auto_reload=0 -> count 5,4,3,2,1,0 on successive edges; tc high only in the cycle count=0; done=1 one edge later; busy=0.
3. Periodic: load 3, auto_reload=1, start -> count 3,2,1,0,3,2,1,0,... with a tc pulse every 4 cycles; done stays 0.
4. Pause/resume: load 9, start, assert stop when count=4 -> count holds at 4, busy=0; start -> next values 3,2,1,0 and tc fires.
5. Collisions:
   - load 7 with start in the same cycle -> count=7, IDLE, start ignored.
   - stop with start in RUN -> IDLE.
   - start with count=0 in IDLE -> no change.
6. Full range (WIDTH=4): load 15, start -> 15 decrements to 0, count never shows 4'hF after 0; start in DONE restarts from 15.
